// File: rtl/fetch_buffer_if.sv
// IF->ID fetch buffer handshake bundle: push side from IF, pop side to ID.
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_pc_plus4;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          stall_if;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus4;
  logic [31:0]   out_instr;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_pc, in_pc_plus4, in_instr, flush, out_ready,
    input  in_ready, stall_if, out_valid, out_pc, out_pc_plus4, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_pc_plus4, in_instr, flush, out_ready,
    output in_ready, stall_if, out_valid, out_pc, out_pc_plus4, out_instr, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular first-word-fall-through instruction buffer between IF and ID.
// Presents a NOP bubble with zero PCs whenever empty; flush drops everything.
module fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic   w_ready;
  logic   w_valid;
  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  // Ready depends only on occupancy so IF never sees a path from ID back-pressure.
  assign w_ready = (r_count < FULL);
  assign w_valid = (r_count != '0);
  assign w_push  = bus.in_valid & w_ready & ~bus.flush;
  assign w_pop   = w_valid & bus.out_ready & ~bus.flush;
  assign w_head  = r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_rd    <= r_wr;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset; the output mux below hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= '{pc: bus.in_pc, pc_plus4: bus.in_pc_plus4, instr: bus.in_instr};
  end

  always_comb begin
    bus.in_ready     = w_ready;
    bus.stall_if     = ~w_ready;
    bus.out_valid    = w_valid;
    bus.count        = r_count;
    bus.out_pc       = 32'h0;
    bus.out_pc_plus4 = 32'h0;
    bus.out_instr    = NOP_INSTR;
    if (w_valid) begin
      bus.out_pc       = w_head.pc;
      bus.out_pc_plus4 = w_head.pc_plus4;
      bus.out_instr    = w_head.instr;
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed table, corner sequences, and random traffic vs a queue model.
module tb_fetch_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_buffer_if #(.DEPTH(DEPTH)) bus ();
  fetch_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } mentry_t;
  mentry_t q[$];

  function automatic logic [31:0] mk_instr(logic [31:0] pc);
    return {pc[23:0], 8'h33} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(logic iv, logic [31:0] pc, logic ordy, logic fl);
    bus.in_valid    = iv;
    bus.in_pc       = pc;
    bus.in_pc_plus4 = pc + 32'd4;
    bus.in_instr    = mk_instr(pc);
    bus.out_ready   = ordy;
    bus.flush       = fl;
  endtask

  // Queue model: flush wins, otherwise pop head if any and append if there was room.
  task automatic tick();
    bit can_push, can_pop;
    @(posedge clk);
    can_push = bus.in_valid && (q.size() < DEPTH);
    can_pop  = bus.out_ready && (q.size() > 0);
    if (bus.flush) q.delete();
    else begin
      if (can_pop) void'(q.pop_front());
      if (can_push) q.push_back('{pc: bus.in_pc, instr: bus.in_instr});
    end
    @(negedge clk);
  endtask

  task automatic chk_model(string tag);
    logic [31:0] epc, einstr;
    epc    = (q.size() > 0) ? q[0].pc : 32'h0;
    einstr = (q.size() > 0) ? q[0].instr : NOP;
    chk({tag, ".count"},     32'(bus.count), 32'(q.size()));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"},  32'(bus.in_ready), 32'(q.size() < DEPTH));
    chk({tag, ".stall_if"},  32'(bus.stall_if), 32'(q.size() >= DEPTH));
    chk({tag, ".out_pc"},    bus.out_pc, epc);
    chk({tag, ".out_pc4"},   bus.out_pc_plus4, (q.size() > 0) ? epc + 32'd4 : 32'h0);
    chk({tag, ".out_instr"}, bus.out_instr, einstr);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    int          e_count;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[$];

  initial begin
    logic [31:0] epc;
    logic [31:0] pcs[$];
    // fill from empty to full, overflow push dropped, drain in order, empty pop ignored
    vecs.push_back('{1, 32'h00, 0, 0, 1, 1, 1, 32'h00});
    vecs.push_back('{1, 32'h04, 0, 0, 2, 1, 1, 32'h00});
    vecs.push_back('{1, 32'h08, 0, 0, 3, 1, 1, 32'h00});
    vecs.push_back('{1, 32'h0C, 0, 0, 4, 1, 0, 32'h00});
    vecs.push_back('{1, 32'h10, 0, 0, 4, 1, 0, 32'h00});
    vecs.push_back('{0, 32'h00, 1, 0, 3, 1, 1, 32'h04});
    vecs.push_back('{0, 32'h00, 1, 0, 2, 1, 1, 32'h08});
    vecs.push_back('{0, 32'h00, 1, 0, 1, 1, 1, 32'h0C});
    vecs.push_back('{0, 32'h00, 1, 0, 0, 0, 1, 32'h00});
    vecs.push_back('{0, 32'h00, 1, 0, 0, 0, 1, 32'h00});

    drive(1, 32'h40, 1, 0);
    #2;
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.out_instr", bus.out_instr, NOP);
    chk("rst.count",     32'(bus.count), 0);
    chk("rst.in_ready",  32'(bus.in_ready), 1);
    chk("rst.stall_if",  32'(bus.stall_if), 0);
    chk("rst.out_pc",    bus.out_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    chk_model("idle");

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
      tick();
      epc = vecs[i].e_pc;
      chk($sformatf("vec%0d.count", i),     32'(bus.count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.in_ready", i),  32'(bus.in_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d.stall_if", i),  32'(bus.stall_if), 32'(!vecs[i].e_ready));
      chk($sformatf("vec%0d.out_pc", i),    bus.out_pc, epc);
      chk($sformatf("vec%0d.out_instr", i), bus.out_instr, vecs[i].e_valid ? mk_instr(epc) : NOP);
    end
    q.delete();

    // streaming: count holds at 1, head lags the push by one cycle across pointer wraps
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h200 + 32'(i) * 4, 1, 0);
      pcs.push_back(32'h200 + 32'(i) * 4);
      tick();
      chk($sformatf("stream%0d.count", i),  32'(bus.count), 1);
      chk($sformatf("stream%0d.out_pc", i), bus.out_pc, pcs[i]);
    end
    drive(0, 0, 1, 0);
    tick();
    q.delete();
    chk_model("stream.drain");

    // flush with simultaneous push and pop on a 3-entry buffer
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i) * 4, 0, 0);
      tick();
    end
    chk_model("preflush");
    drive(1, 32'h3F0, 1, 1);
    tick();
    chk("flush.count",     32'(bus.count), 0);
    chk("flush.out_valid", 32'(bus.out_valid), 0);
    drive(0, 0, 1, 0);
    tick();
    chk("flush.nostore",   32'(bus.out_valid), 0);
    chk_model("postflush");

    // asynchronous reset between edges with two entries held
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h400 + 32'(i) * 4, 0, 0);
      tick();
    end
    chk("arst.pre.count", 32'(bus.count), 2);
    drive(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 0);
    chk("arst.count",     32'(bus.count), 0);
    chk("arst.out_instr", bus.out_instr, NOP);
    #1 rst = 1'b0;
    q.delete();
    drive(1, 32'h100, 0, 0);
    tick();
    chk("arst.resume.pc",    bus.out_pc, 32'h100);
    chk("arst.resume.count", 32'(bus.count), 1);
    drive(0, 0, 0, 0);
    tick();

    // random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(i) * 4,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end
endmodule
